integer_divider: RTL and testbench

Multi-cycle unsigned restoring (shift-subtract) integer divider with a go/done handshake. Divides an n-bit dividend by a WIDTH-bit divisor, one quotient bit per clock, and reports quotient, remainder and an error flag. Used as a small arithmetic slave beside a controlling FSM; the current state is exported for debug.

---
 rtl/divider_pkg.sv | 16 +
 rtl/divider_step.sv | 27 ++
 rtl/integer_divider.sv | 156 +++++++++++++++
 tb/tb_integer_divider.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared constants and state encodings for the restoring integer divider.
// State encodings match the debug cs port of integer_divider.
package divider_pkg;

  localparam int DIV_WIDTH = 4;
  localparam int CS_W      = 4;

  typedef logic [CS_W-1:0] state_t;

  localparam state_t S_IDLE = 4'd0;
  localparam state_t S_LOAD = 4'd1;
  localparam state_t S_ITER = 4'd2;
  localparam state_t S_DONE = 4'd3;
  localparam state_t S_ERR  = 4'd4;

endpackage

// File: rtl/divider_step.sv
// One restoring shift-subtract step: shifts {R,Q} left by one and keeps the
// difference R-D only when it does not go negative, recording that in Q[0].
module divider_step
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   r_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH:0]   r_out,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH+1:0] r_sh;
  logic [WIDTH+1:0] d_ext;
  logic             fits;

  always_comb begin
    r_sh  = {r_in, q_in[WIDTH-1]};
    d_ext = {2'b00, d_in};
    fits  = (r_sh >= d_ext);
    r_out = fits ? (WIDTH+1)'(r_sh - d_ext) : (WIDTH+1)'(r_sh);
    q_out = {q_in[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/integer_divider.sv
// Multi-cycle unsigned restoring divider with go/done handshake, one quotient
// bit per clock. Define DIVIDER_STATE_OUT_EN to expose the FSM state on cs.
module integer_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             error,
  output logic             done,
  output logic [CS_W-1:0]  cs
);

  state_t           state_q,     state_d;
  logic [WIDTH-1:0] d_q,         d_d;
  logic [WIDTH:0]   r_q,         r_d;
  logic [WIDTH-1:0] q_q,         q_d;
  logic [WIDTH-1:0] count_q,     count_d;
  logic [WIDTH-1:0] quotient_q,  quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             error_q,     error_d;
  logic             done_q,      done_d;

  logic [WIDTH:0]   step_r;
  logic [WIDTH-1:0] step_q;
  logic             bad_request;
  logic [WIDTH:0]   mask_wide;
  logic [WIDTH-1:0] shift_amt;

  divider_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .r_in  (r_q),
    .q_in  (q_q),
    .d_in  (d_q),
    .r_out (step_r),
    .q_out (step_q)
  );

  always_comb begin
    bad_request = (divisor == '0) || (n == '0) ||
                  ({1'b0, n} > (WIDTH+1)'(WIDTH));
    // Left-justify the low n dividend bits so the step always consumes Q's MSB.
    mask_wide   = ((WIDTH+1)'(1) << n) - (WIDTH+1)'(1);
    shift_amt   = WIDTH'(WIDTH) - n;
  end

  // NOTE: every _d gets its hold value first so no path through the case
  // leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    d_d         = d_q;
    r_d         = r_q;
    q_d         = q_q;
    count_d     = count_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    error_d     = error_q;
    done_d      = done_q;

    case (state_q)
      S_IDLE: begin
        if (go) begin
          if (bad_request) begin
            state_d     = S_ERR;
            error_d     = 1'b1;
            done_d      = 1'b1;
            quotient_d  = '0;
            remainder_d = '0;
          end else begin
            state_d = S_LOAD;
          end
        end
      end

      S_LOAD: begin
        d_d     = divisor;
        r_d     = '0;
        q_d     = (dividend & mask_wide[WIDTH-1:0]) << shift_amt;
        count_d = n;
        state_d = S_ITER;
      end

      S_ITER: begin
        r_d     = step_r;
        q_d     = step_q;
        count_d = count_q - WIDTH'(1);
        if (count_q == WIDTH'(1)) begin
          state_d     = S_DONE;
          quotient_d  = step_q;
          remainder_d = step_r[WIDTH-1:0];
          done_d      = 1'b1;
        end
      end

      S_DONE, S_ERR: begin
        if (!go) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
          error_d = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
        done_d  = 1'b0;
        error_d = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before this edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      d_q         <= '0;
      r_q         <= '0;
      q_q         <= '0;
      count_q     <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      error_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      d_q         <= d_d;
      r_q         <= r_d;
      q_q         <= q_d;
      count_q     <= count_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      error_q     <= error_d;
      done_q      <= done_d;
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign error     = error_q;
  assign done      = done_q;

`ifdef DIVIDER_STATE_OUT_EN
  assign cs = state_q;
`else
  assign cs = '0;
`endif

endmodule

// File: tb/tb_integer_divider.sv
// Scoreboard bench for integer_divider: a driver issues divisions and queues
// expected results from an arithmetic model; a monitor checks each done.
module tb_integer_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         go  = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor  = '0;
  logic [W-1:0] n        = '0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         error;
  logic         done;
  logic [3:0]   cs;

  integer_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .go        (go),
    .dividend  (dividend),
    .divisor   (divisor),
    .n         (n),
    .quotient  (quotient),
    .remainder (remainder),
    .error     (error),
    .done      (done),
    .cs        (cs)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    int q;
    int r;
    int err;
    int lat;
    int start;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at cycle %0d", name, act, exp, cycle);
    end
  endtask

  // Expected cs value for a given state number, depending on the build option.
  function automatic int exp_cs(input int st);
`ifdef DIVIDER_STATE_OUT_EN
    return st;
`else
    return 0 * st;
`endif
  endfunction

  function automatic exp_t model(input int dvd, input int dvs, input int nn, input int start);
    exp_t e;
    int   a;
    e.start = start;
    e.err   = (dvs == 0 || nn == 0 || nn > W) ? 1 : 0;
    if (e.err != 0) begin
      e.q   = 0;
      e.r   = 0;
      e.lat = 1;
    end else begin
      a     = dvd % (1 << nn);
      e.q   = a / dvs;
      e.r   = a % dvs;
      e.lat = nn + 2;
    end
    return e;
  endfunction

  // Monitor: checks every rising done against the scoreboard, and result
  // stability for as long as done stays high.
  initial begin
    bit   prev = 1'b0;
    exp_t cur;
    cur = '{q: 0, r: 0, err: 0, lat: 0, start: 0};
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
      end else begin
        if (done && !prev) begin
          if (sb.size() == 0) begin
            check("unexpected_done", int'(done), 0);
          end else begin
            cur = sb.pop_front();
            check("quotient", int'(quotient), cur.q);
            check("remainder", int'(remainder), cur.r);
            check("error", int'(error), cur.err);
            check("latency", cycle - cur.start, cur.lat);
            check("cs_result", int'(cs), exp_cs(cur.err != 0 ? 4 : 3));
          end
        end else if (done && prev) begin
          check("hold_quotient", int'(quotient), cur.q);
          check("hold_remainder", int'(remainder), cur.r);
          check("hold_error", int'(error), cur.err);
        end
        prev = done;
      end
    end
  end

  task automatic do_div(input int dvd, input int dvs, input int nn, input int hold);
    exp_t e;
    int   k;
    @(negedge clk);
    dividend = W'(dvd);
    divisor  = W'(dvs);
    n        = W'(nn);
    go       = 1'b1;
    e = model(dvd, dvs, nn, cycle);
    sb.push_back(e);
    if (e.err == 0) begin
      // Once in ITER the operands must no longer matter.
      repeat (2) @(negedge clk);
      dividend = W'($urandom_range(0, 15));
      divisor  = W'($urandom_range(0, 15));
      n        = W'($urandom_range(0, 15));
    end
    k = 0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!done) begin
      check("done_timeout", int'(done), 1);
      sb.delete();
    end
    repeat (hold) @(negedge clk);
    go = 1'b0;
    @(negedge clk);
    check("done_drop", int'(done), 0);
    check("error_drop", int'(error), 0);
    check("cs_idle", int'(cs), exp_cs(0));
  endtask

  task automatic reset_mid_iter();
    exp_t e;
    @(negedge clk);
    dividend = 4'd9;
    divisor  = 4'd2;
    n        = 4'd4;
    go       = 1'b1;
    e = model(9, 2, 4, cycle);
    sb.push_back(e);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_cs", int'(cs), 0);
    check("rst_quotient", int'(quotient), 0);
    check("rst_remainder", int'(remainder), 0);
    check("rst_done", int'(done), 0);
    check("rst_error", int'(error), 0);
    sb.delete();
    go = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    check("reset_cs", int'(cs), 0);
    check("reset_quotient", int'(quotient), 0);
    check("reset_remainder", int'(remainder), 0);
    check("reset_done", int'(done), 0);
    check("reset_error", int'(error), 0);
    rst = 1'b0;

    do_div(4, 3, 4, 0);
    do_div(15, 4, 4, 1);
    do_div(9, 0, 4, 0);
    do_div(7, 7, 4, 2);
    do_div(15, 2, 2, 0);
    reset_mid_iter();
    do_div(13, 3, 4, 0);
    do_div(5, 3, 0, 0);
    do_div(5, 3, 5, 1);
    do_div(13, 5, 4, 10);
    do_div(11, 2, 3, 0);
    do_div(1, 1, 1, 0);
    do_div(15, 15, 4, 0);
    do_div(15, 1, 4, 0);

    for (int i = 0; i < 40; i++) begin
      do_div($urandom_range(0, 15), $urandom_range(0, 15),
             $urandom_range(0, 6), $urandom_range(0, 3));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
